// File: rtl/uart_hex_cmd_parser_if.sv
// FIFO-side handshake bundle for uart_hex_cmd_parser: rx FIFO pop port and tx FIFO push port.
// master = parser side, slave = FIFO side.
interface uart_hex_cmd_parser_if #(
    parameter int DBIT = 8
);
    logic            rx_empty;
    logic [DBIT-1:0] rd_data;
    logic            rd_uart;
    logic            tx_full;
    logic            wr_uart;
    logic [DBIT-1:0] wr_data;

    modport master (
        input  rx_empty, rd_data, tx_full,
        output rd_uart, wr_uart, wr_data
    );

    modport slave (
        output rx_empty, rd_data, tx_full,
        input  rd_uart, wr_uart, wr_data
    );
endinterface

// File: rtl/uart_hex_cmd_parser.sv
// Pops bytes from the uart rx FIFO, accumulates ASCII hex digits and commits the value on CR.
// Optional byte echo to the tx FIFO is compiled in when UART_HEX_ECHO_EN is defined.
module uart_hex_cmd_parser #(
    parameter int DBIT    = 8,
    parameter int NIBBLES = 4,
    parameter int CNT_W   = 3
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    uart_hex_cmd_parser_if.master  bus,
    output logic [4*NIBBLES-1:0]   o_value,
    output logic                   o_valid,
    output logic                   o_ovf,
    output logic                   o_err
);
    localparam int DATA_W = 4 * NIBBLES;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_POP    = 2'd1,
`ifdef UART_HEX_ECHO_EN
        S_DECODE = 2'd2,
        S_ECHO   = 2'd3
`else
        S_DECODE = 2'd2
`endif
    } state_t;

    typedef struct packed {
        logic       hex;
        logic       cr;
        logic       lf;
        logic [3:0] nib;
    } dec_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] value_q, value_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic              err_q, err_d;
    logic              rd_uart_q, rd_uart_d;
    logic [7:0]        rx_byte;
    dec_t              dec;

    assign rx_byte = bus.rd_data[7:0];

    // Classification runs on the FIFO head during S_POP so the result lands
    // in registers as the FSM enters S_DECODE.
    always_comb begin
        dec = '0;
        if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
            dec.hex = 1'b1;
            dec.nib = rx_byte[3:0];
        end else if ((rx_byte >= 8'h41 && rx_byte <= 8'h46) ||
                     (rx_byte >= 8'h61 && rx_byte <= 8'h66)) begin
            dec.hex = 1'b1;
            dec.nib = rx_byte[3:0] + 4'd9;
        end else if (rx_byte == 8'h0D) begin
            dec.cr = 1'b1;
        end else if (rx_byte == 8'h0A) begin
            dec.lf = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (!bus.rx_empty) state_d = S_POP;
            S_POP:    state_d = S_DECODE;
`ifdef UART_HEX_ECHO_EN
            S_DECODE: state_d = S_ECHO;
            S_ECHO:   if (!bus.tx_full) state_d = S_IDLE;
`else
            S_DECODE: state_d = S_IDLE;
`endif
            default:  state_d = S_IDLE;
        endcase
    end

`ifdef UART_HEX_ECHO_EN
    logic [DBIT-1:0] byte_q, byte_d;
    logic            wr_uart_q, wr_uart_d;
    logic [DBIT-1:0] wr_data_q, wr_data_d;
`endif

    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        value_d   = value_q;
        valid_d   = 1'b0;
        ovf_d     = ovf_q;
        err_d     = 1'b0;
        rd_uart_d = 1'b0;
`ifdef UART_HEX_ECHO_EN
        byte_d    = byte_q;
        wr_uart_d = 1'b0;
        wr_data_d = wr_data_q;
`endif
        case (state_q)
            S_IDLE: rd_uart_d = !bus.rx_empty;
            S_POP: begin
`ifdef UART_HEX_ECHO_EN
                byte_d = bus.rd_data;
`endif
                if (dec.hex) begin
                    acc_d = {acc_q[DATA_W-5:0], dec.nib};
                    // Saturate one past NIBBLES so overflow stays visible at commit.
                    if (cnt_q <= CNT_W'(NIBBLES)) cnt_d = cnt_q + CNT_W'(1);
                end else if (dec.cr) begin
                    if (cnt_q != '0) begin
                        value_d = acc_q;
                        valid_d = 1'b1;
                        ovf_d   = (cnt_q > CNT_W'(NIBBLES));
                        acc_d   = '0;
                        cnt_d   = '0;
                    end
                end else if (!dec.lf) begin
                    err_d = 1'b1;
                    acc_d = '0;
                    cnt_d = '0;
                end
            end
`ifdef UART_HEX_ECHO_EN
            S_ECHO: begin
                if (!bus.tx_full) begin
                    wr_uart_d = 1'b1;
                    wr_data_d = byte_q;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            value_q   <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
            rd_uart_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            value_q   <= value_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
            rd_uart_q <= rd_uart_d;
        end
    end

`ifdef UART_HEX_ECHO_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            byte_q    <= '0;
            wr_uart_q <= 1'b0;
            wr_data_q <= '0;
        end else begin
            byte_q    <= byte_d;
            wr_uart_q <= wr_uart_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.wr_uart = wr_uart_q;
    assign bus.wr_data = wr_data_q;
`else
    assign bus.wr_uart = 1'b0;
    assign bus.wr_data = '0;
`endif

    assign bus.rd_uart = rd_uart_q;
    assign o_value     = value_q;
    assign o_valid     = valid_q;
    assign o_ovf       = ovf_q;
    assign o_err       = err_q;
endmodule

// File: tb/tb_uart_hex_cmd_parser.sv
// Directed bench for uart_hex_cmd_parser with simple rx/tx FIFO models.
module tb_uart_hex_cmd_parser;
    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [15:0] o_value;
    logic        o_valid, o_ovf, o_err;

    uart_hex_cmd_parser_if #(.DBIT(8)) bus ();

    uart_hex_cmd_parser #(.DBIT(8), .NIBBLES(4), .CNT_W(3)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus),
        .o_value (o_value),
        .o_valid (o_valid),
        .o_ovf   (o_ovf),
        .o_err   (o_err)
    );

    always #5 i_clk = ~i_clk;

    logic [7:0] mem [0:255];
    int wptr = 0;
    int rptr = 0;
    int pops = 0, pop_empty = 0, valids = 0, errs = 0, pushes = 0, push_full = 0;
    logic [7:0] txq [$];
    int passed = 0, total = 0;

    // rx FIFO read side and event monitors; the FIFO pops on the edge that ends a strobe cycle.
    always @(posedge i_clk) begin
        if (!i_reset) begin
            if (bus.rd_uart) begin
                if (rptr == wptr) pop_empty++;
                else rptr++;
                pops++;
            end
            if (bus.wr_uart) begin
                if (bus.tx_full) push_full++;
                txq.push_back(bus.wr_data);
                pushes++;
            end
            if (o_valid) valids++;
            if (o_err) errs++;
        end
        bus.rx_empty <= (rptr == wptr);
        bus.rd_data  <= mem[rptr[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic feed(input string s);
        @(negedge i_clk);
        for (int i = 0; i < s.len(); i++) begin
            mem[wptr[7:0]] = s[i];
            wptr++;
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (rptr != wptr && n < 400) begin
            @(negedge i_clk);
            n++;
        end
        repeat (6) @(negedge i_clk);
        check({tag, "_drained"}, (rptr == wptr), 1);
    endtask

    initial begin
        int base_push, base_pop, base_valid, seen, n;
        bus.tx_full = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (3) @(negedge i_clk);
        check("rst_value",   o_value,     16'h0000);
        check("rst_valid",   o_valid,     1'b0);
        check("rst_ovf",     o_ovf,       1'b0);
        check("rst_err",     o_err,       1'b0);
        check("rst_rd_uart", bus.rd_uart, 1'b0);
        check("rst_wr_uart", bus.wr_uart, 1'b0);
        check("rst_wr_data", bus.wr_data, 8'h00);
        i_reset = 1'b0;

        feed("1A2F\015"); drain("t1");
        check("t1_valids", valids,  1);
        check("t1_value",  o_value, 16'h1A2F);
        check("t1_ovf",    o_ovf,   1'b0);
        check("t1_pops",   pops,    5);
        check("t1_errs",   errs,    0);

        feed("abc\015"); drain("t2a");
        check("t2_valids", valids,  2);
        check("t2_value",  o_value, 16'h0ABC);
        feed("\015"); drain("t2b");
        check("t2_cr_only_valids", valids,  2);
        check("t2_cr_only_value",  o_value, 16'h0ABC);
        check("t2_pops",           pops,    10);

        feed("123456\015"); drain("t3a");
        check("t3_valids", valids,  3);
        check("t3_value",  o_value, 16'h3456);
        check("t3_ovf",    o_ovf,   1'b1);
        feed("7\015"); drain("t3b");
        check("t3_value7", o_value, 16'h0007);
        check("t3_ovf7",   o_ovf,   1'b0);

        feed("12G3\015"); drain("t4");
        check("t4_errs",      errs,      1);
        check("t4_valids",    valids,    5);
        check("t4_value",     o_value,   16'h0003);
        check("t4_pop_empty", pop_empty, 0);

        feed("4\0125\015"); drain("lf");
        check("lf_value", o_value, 16'h0045);
        check("lf_errs",  errs,    1);

        feed("ffff\015"); drain("ff");
        check("ff_value", o_value, 16'hFFFF);
        check("ff_ovf",   o_ovf,   1'b0);
        check("ff_valids", valids, 7);

`ifdef UART_HEX_ECHO_EN
        check("echo_all", pushes, pops);
        base_push  = pushes;
        base_pop   = pops;
        base_valid = valids;
        bus.tx_full = 1'b1;
        feed("5\015");
        repeat (20) @(negedge i_clk);
        check("t5_no_push_full", pushes, base_push);
        check("t5_pop_stall",    pops,   base_pop + 1);
        bus.tx_full = 1'b0;
        drain("t5");
        check("t5_pushes",    pushes, base_push + 2);
        check("t5_echo_5",    (txq.size() > base_push) ? txq[base_push] : 8'hXX, 8'h35);
        check("t5_echo_cr",   (txq.size() > base_push + 1) ? txq[base_push + 1] : 8'hXX, 8'h0D);
        check("t5_value",     o_value, 16'h0005);
        check("t5_valids",    valids, base_valid + 1);
        check("t5_push_full", push_full, 0);
`else
        check("noecho_pushes",  pushes,      0);
        check("noecho_wr_data", bus.wr_data, 8'h00);
`endif

        // Reset lands while the second digit sits in S_DECODE.
        feed("12");
        seen = 0;
        n = 0;
        while (seen < 2 && n < 100) begin
            @(negedge i_clk);
            n++;
            if (bus.rd_uart) seen++;
        end
        check("t6_two_pops", seen, 2);
        @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        check("t6_rst_value",   o_value,     16'h0000);
        check("t6_rst_ovf",     o_ovf,       1'b0);
        check("t6_rst_rd_uart", bus.rd_uart, 1'b0);
        check("t6_rst_wr_uart", bus.wr_uart, 1'b0);
        i_reset = 1'b0;
        feed("9\015"); drain("t6");
        check("t6_value", o_value, 16'h0009);
        check("t6_ovf",   o_ovf,   1'b0);
        check("t6_pop_empty", pop_empty, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
